// File: rtl/pca24s08a_pkg.sv
// Shared constants, address type and FSM state encoding for the PCA24S08A EEPROM responder.
package pca24s08a_pkg;

    localparam logic [3:0] DEV_TYPE  = 4'b1010;
    localparam int         MEM_DEPTH = 1024;
    localparam int         PAGE_SIZE = 16;

    typedef logic [9:0] mem_addr_t;
    typedef logic [3:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE      = 4'd0;
    localparam fsm_state_t ST_DEV_ADDR  = 4'd1;
    localparam fsm_state_t ST_DEV_ACK   = 4'd2;
    localparam fsm_state_t ST_WORD_ADDR = 4'd3;
    localparam fsm_state_t ST_WORD_ACK  = 4'd4;
    localparam fsm_state_t ST_WR_DATA   = 4'd5;
    localparam fsm_state_t ST_WR_ACK    = 4'd6;
    localparam fsm_state_t ST_RD_DATA   = 4'd7;
    localparam fsm_state_t ST_RD_ACK    = 4'd8;
    localparam fsm_state_t ST_IGNORE    = 4'd9;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes scl/sda into the clk domain and flags START, STOP and scl edges.
module i2c_bus_monitor (
    input  logic clk,
    input  logic arstn,
    input  logic scl,
    input  logic sda,
    output logic start_det,
    output logic stop_det,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s
);

    // Bit 0 is the metastability flop, bit 1 the synchronized level, bit 2 the history.
    logic [2:0] scl_pipe;
    logic [2:0] sda_pipe;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            scl_pipe <= 3'b111;
            sda_pipe <= 3'b111;
        end else begin
            scl_pipe <= {scl_pipe[1:0], scl};
            sda_pipe <= {sda_pipe[1:0], sda};
        end
    end

    assign scl_rise  =  scl_pipe[1] & ~scl_pipe[2];
    assign scl_fall  = ~scl_pipe[1] &  scl_pipe[2];
    assign start_det =  scl_pipe[1] &  scl_pipe[2] &  sda_pipe[2] & ~sda_pipe[1];
    assign stop_det  =  scl_pipe[1] &  scl_pipe[2] & ~sda_pipe[2] &  sda_pipe[1];
    assign sda_s     =  sda_pipe[1];

endmodule

// File: rtl/pca24s08a_responder.sv
// I2C responder emulating a PCA24S08A 1 KiB EEPROM: page writes, current/random/sequential reads.
module pca24s08a_responder
    import pca24s08a_pkg::*;
#(
    parameter logic       DEV_A2   = 1'b1,
    parameter logic [7:0] INIT_VAL = 8'hFF
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       scl,
    inout  wire        sda,
    output logic       wr_valid,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    logic       start_det;
    logic       stop_det;
    logic       scl_rise;
    logic       scl_fall;
    logic       sda_s;

    fsm_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] tx_byte;
    mem_addr_t  pointer;
    logic       ack_phase;
    logic       sda_low;
    logic       addr_match;
    logic [7:0] mem [MEM_DEPTH];

    i2c_bus_monitor u_monitor (
        .clk       (clk),
        .arstn     (arstn),
        .scl       (scl),
        .sda       (sda),
        .start_det (start_det),
        .stop_det  (stop_det),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s)
    );

    assign sda        = sda_low ? 1'b0 : 1'bz;
    assign addr_match = (shift_reg[7:3] == {DEV_TYPE, DEV_A2});

    // Each ACK state spans two scl falls: the first starts the 9th clock, the second ends it.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_byte   <= '0;
            pointer   <= '0;
            ack_phase <= 1'b0;
            sda_low   <= 1'b0;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= INIT_VAL;
            end
        end else begin
            wr_valid <= 1'b0;
            if (start_det) begin
                state     <= ST_DEV_ADDR;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                sda_low   <= 1'b0;
            end else if (stop_det) begin
                state     <= ST_IDLE;
                ack_phase <= 1'b0;
                sda_low   <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_IGNORE: ;
                    ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_s};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= (state == ST_DEV_ADDR)  ? ST_DEV_ACK  :
                                         (state == ST_WORD_ADDR) ? ST_WORD_ACK : ST_WR_ACK;
                            end
                        end
                    end
                    ST_DEV_ACK: begin
                        if (scl_fall && !ack_phase) begin
                            if (addr_match) begin
                                ack_phase    <= 1'b1;
                                sda_low      <= 1'b1;
                                pointer[9:8] <= shift_reg[2:1];
                                busy         <= 1'b1;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end else if (scl_fall) begin
                            ack_phase <= 1'b0;
                            if (shift_reg[0]) begin
                                state   <= ST_RD_DATA;
                                tx_byte <= mem[pointer];
                                sda_low <= ~mem[pointer][7];
                            end else begin
                                state   <= ST_WORD_ADDR;
                                sda_low <= 1'b0;
                            end
                        end
                    end
                    ST_WORD_ACK: begin
                        if (scl_fall && !ack_phase) begin
                            ack_phase    <= 1'b1;
                            sda_low      <= 1'b1;
                            pointer[7:0] <= shift_reg;
                        end else if (scl_fall) begin
                            ack_phase <= 1'b0;
                            sda_low   <= 1'b0;
                            state     <= ST_WR_DATA;
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall && !ack_phase) begin
                            ack_phase <= 1'b1;
                            sda_low   <= 1'b1;
                        end else if (scl_fall) begin
                            mem[pointer] <= shift_reg;
                            wr_valid     <= 1'b1;
                            wr_addr      <= pointer;
                            wr_data      <= shift_reg;
                            pointer[3:0] <= pointer[3:0] + 4'd1;
                            ack_phase    <= 1'b0;
                            sda_low      <= 1'b0;
                            state        <= ST_WR_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_RD_ACK;
                            end
                        end else if (scl_fall) begin
                            tx_byte <= {tx_byte[6:0], 1'b0};
                            sda_low <= ~tx_byte[6];
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_fall && !ack_phase) begin
                            ack_phase <= 1'b1;
                            sda_low   <= 1'b0;
                        end else if (scl_rise && ack_phase) begin
                            pointer <= pointer + 10'd1;
                            if (sda_s) begin
                                state     <= ST_IGNORE;
                                ack_phase <= 1'b0;
                                busy      <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            ack_phase <= 1'b0;
                            state     <= ST_RD_DATA;
                            tx_byte   <= mem[pointer];
                            sda_low   <= ~mem[pointer][7];
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
